// File: rtl/gate_test_sequencer.sv
// Truth-table sequencer for a 2-input cell: applies each vector, settles, samples, scores.
// Optional GATE_SEQ_ABORT_EN: the first mismatch ends the run immediately.
module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [3:0] err_cnt
);

  localparam int unsigned ERR_MAX     = 15;
  localparam logic [2:0]  SETTLE_LAST = 3'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [3:0]  SWEEP_LAST  = 4'(PASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [1:0] r_mode;
  logic [1:0] r_idx;
  logic [3:0] r_sweep;
  logic [2:0] r_settle;
  logic       r_dut_a;
  logic       r_dut_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_fail_vec;
  logic [3:0] r_err_cnt;

  logic       w_exp;
  logic       w_mismatch;
  logic       w_last;
  logic       w_abort;
  logic [1:0] w_idx_nxt;
  logic [3:0] w_err_nxt;

  // Expected cell output for the vector currently on the cell inputs
  always_comb begin
    w_exp = 1'b0;
    unique case (r_mode)
      2'b00: w_exp = ~(r_dut_a | r_dut_b);
      2'b01: w_exp = r_dut_a & r_dut_b;
      2'b10: w_exp = r_dut_a | r_dut_b;
      2'b11: w_exp = r_dut_a ^ r_dut_b;
    endcase
  end

  assign w_mismatch = (r_state == S_SAMPLE) && (dut_y != w_exp);
  assign w_err_nxt  = (w_mismatch && (r_err_cnt != 4'(ERR_MAX))) ? r_err_cnt + 4'd1 : r_err_cnt;
  assign w_last     = (r_idx == 2'd3) && (r_sweep == SWEEP_LAST);
  assign w_idx_nxt  = r_idx + 2'd1;

`ifdef GATE_SEQ_ABORT_EN
  assign w_abort = w_mismatch;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mode     <= 2'd0;
      r_idx      <= 2'd0;
      r_sweep    <= 4'd0;
      r_settle   <= 3'd0;
      r_dut_a    <= 1'b0;
      r_dut_b    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail_vec <= 4'd0;
      r_err_cnt  <= 4'd0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mode     <= mode;
            r_fail_vec <= 4'd0;
            r_err_cnt  <= 4'd0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_idx      <= 2'd0;
            r_sweep    <= 4'd0;
            r_dut_a    <= 1'b0;
            r_dut_b    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_APPLY;
          end
        end
        S_APPLY: begin
          r_settle <= 3'd0;
          r_state  <= (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle == SETTLE_LAST) r_state <= S_SAMPLE;
          else                         r_settle <= r_settle + 3'd1;
        end
        S_SAMPLE: begin
          r_err_cnt <= w_err_nxt;
          if (w_mismatch) r_fail_vec[r_idx] <= 1'b1;
          if (w_last || w_abort) begin
            // Pass uses the post-sample count so the final vector is included
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == 4'd0);
            r_dut_a <= 1'b0;
            r_dut_b <= 1'b0;
            r_state <= S_DONE;
          end else begin
            if (r_idx == 2'd3) r_sweep <= r_sweep + 4'd1;
            r_idx   <= w_idx_nxt;
            r_dut_a <= w_idx_nxt[1];
            r_dut_b <= w_idx_nxt[0];
            r_state <= S_APPLY;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dut_a    = r_dut_a;
  assign dut_b    = r_dut_b;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign fail_vec = r_fail_vec;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Randomized bench for gate_test_sequencer: a per-sweep truth table stands in for the cell,
// and expected outputs are derived cycle-by-cycle from the vector timing rules.
module tb_gate_test_sequencer;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned PASSES = 4;
  localparam int unsigned L      = SETTLE + 2;
  localparam int unsigned NVEC   = 4 * PASSES;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode  = 2'd0;
  logic       dut_y;
  logic       dut_a, dut_b, busy, done, pass;
  logic [3:0] fail_vec, err_cnt;
  logic [3:0] cur_tbl = 4'd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Cell stand-in: bit i of the active table is the output for vector {a,b}=i
  assign dut_y = cur_tbl[{dut_a, dut_b}];

  gate_test_sequencer #(.SETTLE_CYCLES(SETTLE), .PASSES(PASSES)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .dut_y    (dut_y),
    .dut_a    (dut_a),
    .dut_b    (dut_b),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_vec (fail_vec),
    .err_cnt  (err_cnt)
  );

  // Reference truth tables, bit i = expected output for vector i
  function automatic logic [3:0] truth(input logic [1:0] m);
    case (m)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b1000;
      2'b10:   return 4'b1110;
      default: return 4'b0110;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".pass"}, 32'(pass), 32'd0);
    chk({tag, ".a"}, 32'(dut_a), 32'd0);
    chk({tag, ".b"}, 32'(dut_b), 32'd0);
    chk({tag, ".fv"}, 32'(fail_vec), 32'd0);
    chk({tag, ".err"}, 32'(err_cnt), 32'd0);
  endtask

  // One run: tbls[4s+:4] is the cell behaviour during sweep s.
  // start2_at / rst_at: cycle index after E0 for an extra start pulse / an async reset (-1 = none).
  task automatic run(input logic [1:0] m, input logic [15:0] tbls, input int start2_at, input int rst_at);
    logic [3:0]  want;
    logic [15:0] mis;
    int          nvec;
    int          total;
    int          k;
    logic [1:0]  v;
    logic [3:0]  fv;
    int          err;
    bit          was_reset;

    want = truth(m);
    for (int j = 0; j < NVEC; j++) mis[j] = (tbls[4*(j/4) + (j%4)] != want[j%4]);
    nvec = NVEC;
`ifdef GATE_SEQ_ABORT_EN
    for (int j = 0; j < NVEC; j++) begin
      if (mis[j]) begin
        nvec = j + 1;
        break;
      end
    end
`endif
    total     = nvec * L;
    fv        = 4'd0;
    err       = 0;
    was_reset = 1'b0;

    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;

    for (int n = 0; n < total; n++) begin
      k       = n / L;
      v       = 2'(k % 4);
      cur_tbl = tbls[4*(k/4) +: 4];
      mode    = 2'($urandom);
      if (n > 0 && (n % L) == 0 && mis[k-1]) begin
        fv[(k-1)%4] = 1'b1;
        err = (err < 15) ? err + 1 : 15;
      end
      chk("run.busy", 32'(busy), 32'd1);
      chk("run.done", 32'(done), 32'd0);
      chk("run.pass", 32'(pass), 32'd0);
      chk("run.a", 32'(dut_a), 32'(v[1]));
      chk("run.b", 32'(dut_b), 32'(v[0]));
      chk("run.fv", 32'(fail_vec), 32'(fv));
      chk("run.err", 32'(err_cnt), 32'(err));
      if (n == rst_at) begin
        rst_n = 1'b0;
        #2;
        chk_all_zero("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk_all_zero("rst.idle");
        was_reset = 1'b1;
        break;
      end
      start = (n == start2_at);
      tick();
      start = 1'b0;
    end

    if (!was_reset) begin
      if (mis[nvec-1]) begin
        fv[(nvec-1)%4] = 1'b1;
        err = (err < 15) ? err + 1 : 15;
      end
      for (int h = 0; h < 2; h++) begin
        chk("end.busy", 32'(busy), 32'd0);
        chk("end.done", 32'(done), 32'd1);
        chk("end.pass", 32'(pass), 32'(err == 0));
        chk("end.a", 32'(dut_a), 32'd0);
        chk("end.b", 32'(dut_b), 32'd0);
        chk("end.fv", 32'(fail_vec), 32'(fv));
        chk("end.err", 32'(err_cnt), 32'(err));
        tick();
      end
    end
  endtask

  initial begin
    logic [15:0] t;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_all_zero("idle");

    // Directed scenarios: good NOR, stuck-at-0, stuck-at-1, NOR scored as XOR
    run(2'b00, {4{4'b0001}}, -1, -1);
    run(2'b00, {4{4'b0000}}, -1, -1);
    run(2'b00, {4{4'b1111}}, -1, -1);
    run(2'b11, {4{4'b0001}}, -1, -1);
    // All four vectors wrong every sweep: count saturates at 15
    run(2'b01, {4{4'b0111}}, -1, -1);

    // Extra start mid-run is ignored, reset at cycle 30, then a clean run from IDLE
    run(2'b00, {4{4'b0001}}, 10, 30);
    run(2'b00, {4{4'b0001}}, -1, -1);

    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(1, 0) == 1) t = 16'($urandom);
      else                           t = {4{4'($urandom)}};
      run(2'($urandom), t, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
